ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the IDU decoder.
- Holds the PC and issues one instruction-memory read per instruction. Captures the returned word and presents `inst`/`inst_pc` to the IDU with a valid/ready handshake.
- Waits for the next PC from write-back before fetching again. Multi-cycle NPC, so only one instruction is in flight at a time.

Parameters:
- ISA_WIDTH, 32, instruction and address width.
- RESET_PC, 32'h80000000, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_next_valid  in  1  downstream offers the next PC.
- pc_next  in  ISA_WIDTH  next PC value (sequential or redirect).
- pc_next_ready  out  1  IFU accepts pc_next this cycle.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ISA_WIDTH  read address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  ISA_WIDTH  read data.
- inst_valid  out  1  instruction available to the IDU.
- inst  out  ISA_WIDTH  fetched instruction word.
- inst_pc  out  ISA_WIDTH  PC of `inst`.
- inst_ready  in  1  IDU consumes the instruction this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC.
  - inst=0, inst_pc=0.
  - inst_valid=0, imem_req=0, pc_next_ready=0.
- States and transitions:
  - S_IDLE: outputs idle. Next cycle goes to S_FETCH. Spent once after reset release.
  - S_FETCH:
    - imem_req=1, imem_addr={pc[ISA_WIDTH-1:2],2'b00}.
    - Hold req and addr stable until imem_gnt=1.
    - gnt&&!rvalid goes to S_WAIT.
    - gnt&&rvalid in the same cycle captures data and goes straight to S_VALID.
  - S_WAIT:
    - imem_req=0.
    - On imem_rvalid, register inst<=imem_rdata and inst_pc<=pc, then go to S_VALID.
  - S_VALID:
    - inst_valid=1.
    - inst and inst_pc stay stable while inst_ready=0.
    - On inst_ready, go to S_NEXT; inst_valid is 0 the following cycle.
  - S_NEXT:
    - pc_next_ready=1.
    - On pc_next_valid, set pc<=pc_next and go to S_FETCH.
- Latency: the first imem_req is asserted 1 cycle after reset release. Minimum round trip from pc_next accept back to inst_valid is 2 cycles (FETCH with same-cycle gnt+rvalid, then VALID).
- Ignored inputs:
  - imem_rvalid outside S_FETCH/S_WAIT is ignored.
  - pc_next_valid outside S_NEXT is ignored and not buffered.
  - inst_ready while inst_valid=0 is ignored.
- The pc register keeps all bits of the accepted pc_next; imem_addr always masks [1:0].
- PC arithmetic is not performed here; pc_next is fully computed downstream.
- Reset asserted mid-operation (any state) returns to S_IDLE and discards any outstanding response. The memory side is reset by the same rst.
- inst_valid and pc_next_ready are never high in the same cycle.

Optional Feature:
- Macro: IFU_MISALIGN_EN.
- Defined:
  - Adds output `inst_misalign` (1 bit, reset 0).
  - In S_NEXT, an accepted pc_next with [1:0]!=0 skips S_FETCH and issues no imem_req.
  - It enters S_VALID with inst=0, inst_pc=pc_next, inst_misalign=1.
  - inst_misalign clears when the instruction is consumed. A normal fetch always gives inst_misalign=0.
- Undefined: no extra port; misaligned PCs are fetched at the word-aligned address.

Test Plan:
- Reset release: imem_req=0 for cycle 0 after release. Cycle 1 gives imem_req=1, imem_addr=32'h80000000.
- imem_gnt held 0 for 3 cycles: imem_req=1 and imem_addr stable all 3 cycles. gnt then rvalid 2 cycles later with rdata=32'h00100073: inst_valid=1, inst=32'h00100073, inst_pc=32'h80000000.
- Same-cycle gnt+rvalid with rdata=32'h00000013: inst_valid is asserted the next cycle (no S_WAIT).
- Backpressure: inst_ready=0 for 4 cycles keeps inst/inst_pc constant. pc_next_valid=1 during that time does not produce pc_next_ready.
- In S_NEXT, pc_next=32'h80000010 is accepted. The next fetch uses imem_addr=32'h80000010, and the returned word carries inst_pc=32'h80000010.
- rst=0 pulsed while in S_WAIT: all outputs are immediately 0. A late imem_rvalid is ignored, and the fetch restarts at 32'h80000000.
- With IFU_MISALIGN_EN defined: pc_next=32'h80000002 gives no imem_req, inst_valid=1, inst_misalign=1, inst_pc=32'h80000002.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundle of the instruction-fetch stage's three handshakes.
//   - pc_next_*  : next PC from write-back into the IFU
//   - imem_*     : request/grant + response to instruction memory
//   - inst_*     : fetched instruction out to the IDU
// Optional port inst_misalign exists only when IFU_MISALIGN_EN is defined.
//
// Handshake semantics: a transfer happens on a rising clk edge where the
// sender's valid (pc_next_valid, imem_req, inst_valid) and the receiver's
// ready (pc_next_ready, imem_gnt, inst_ready) are both high. The sender
// keeps payload stable while valid is high and ready is low. imem_rvalid is
// an unconditional response strobe (no back-pressure on read data).
interface ifu_fetch_if #(
  parameter int ISA_WIDTH = 32
);
  logic                 pc_next_valid;
  logic [ISA_WIDTH-1:0] pc_next;
  logic                 pc_next_ready;

  logic                 imem_req;
  logic [ISA_WIDTH-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [ISA_WIDTH-1:0] imem_rdata;

  logic                 inst_valid;
  logic [ISA_WIDTH-1:0] inst;
  logic [ISA_WIDTH-1:0] inst_pc;
  logic                 inst_ready;
`ifdef IFU_MISALIGN_EN
  logic                 inst_misalign;
`endif

  // IFU side
  modport master (
    input  pc_next_valid, pc_next,
    output pc_next_ready,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst, inst_pc,
`ifdef IFU_MISALIGN_EN
    output inst_misalign,
`endif
    input  inst_ready
  );

  // Environment side (write-back, memory, IDU)
  modport slave (
    output pc_next_valid, pc_next,
    input  pc_next_ready,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst, inst_pc,
`ifdef IFU_MISALIGN_EN
    input  inst_misalign,
`endif
    output inst_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage feeding the IDU.
// Holds the PC, issues one memory read per instruction, presents the word
// to the decoder and then waits for the next PC from write-back.
// Optional feature macro: IFU_MISALIGN_EN -- a misaligned next PC skips the
// memory read and is handed to the IDU flagged with inst_misalign.
// Reset: rst is asynchronous, active low.
module ifu_fetch #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ISA_WIDTH-1:0] pc;
  logic [ISA_WIDTH-1:0] inst_q;
  logic [ISA_WIDTH-1:0] inst_pc_q;

  // capture: load memory read data into the instruction register
  // accept : pc_next handshake completes this cycle
  logic capture;
  logic accept;
`ifdef IFU_MISALIGN_EN
  logic skip;          // accepted pc_next is misaligned, bypass the fetch
  logic misalign_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
`ifdef IFU_MISALIGN_EN
    skip      = 1'b0;
`endif
    case (state)
      // one dead cycle after reset release
      S_IDLE: state_nxt = S_FETCH;
      // request held until granted; data may return with the grant
      S_FETCH: begin
        if (bus.imem_gnt) begin
          if (bus.imem_rvalid) begin
            capture   = 1'b1;
            state_nxt = S_VALID;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          capture   = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.inst_ready) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (bus.pc_next_valid) begin
          accept    = 1'b1;
          state_nxt = S_FETCH;
`ifdef IFU_MISALIGN_EN
          if (bus.pc_next[1:0] != 2'b00) begin
            skip      = 1'b1;
            state_nxt = S_VALID;
          end
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Program counter: keeps every bit of the accepted next PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pc <= RESET_PC;
    else if (accept) pc <= bus.pc_next;
  end

  // Instruction word and its PC; stable while waiting on the IDU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else if (capture) begin
      inst_q    <= bus.imem_rdata;
      inst_pc_q <= pc;
`ifdef IFU_MISALIGN_EN
    end else if (skip) begin
      inst_q    <= '0;
      inst_pc_q <= bus.pc_next;
`endif
    end
  end

`ifdef IFU_MISALIGN_EN
  // Misalign flag: set on a skipped fetch, cleared on consume or real fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      misalign_q <= 1'b0;
    else if (skip)                                 misalign_q <= 1'b1;
    else if (capture)                              misalign_q <= 1'b0;
    else if (state == S_VALID && bus.inst_ready)   misalign_q <= 1'b0;
  end

  assign bus.inst_misalign = misalign_q;
`endif

  // Moore outputs; the address is zeroed whenever no request is offered so
  // the whole output bundle reads 0 in reset and idle states.
  assign bus.imem_req      = (state == S_FETCH);
  assign bus.imem_addr     = bus.imem_req ? {pc[ISA_WIDTH-1:2], 2'b00} : '0;
  assign bus.inst_valid    = (state == S_VALID);
  assign bus.pc_next_ready = (state == S_NEXT);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table, reset-in-flight sequence, randomized
// transactions against a transaction-level model, and the misaligned-PC case.
module tb_ifu_fetch;
  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h80000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  ifu_fetch_if #(.ISA_WIDTH(W)) bus();

  ifu_fetch #(.ISA_WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // memory contents model: a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h01000193) ^ 32'h00000013;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        rdy, pnv;
    logic [31:0] pnext;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        e_pnr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic pnv, input logic [31:0] pn,
                              input logic req, input logic [31:0] addr, input logic iv,
                              input logic [31:0] ins, input logic [31:0] ipc, input logic pnr);
    vec_t v;
    v.gnt = gnt; v.rvalid = rv; v.rdata = rd; v.rdy = rdy; v.pnv = pnv; v.pnext = pn;
    v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_inst = ins; v.e_ipc = ipc; v.e_pnr = pnr;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.pc_next_valid = 1'b0;
    bus.pc_next       = '0;
    bus.imem_gnt      = 1'b0;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = '0;
    bus.inst_ready    = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                           input logic pnr);
    chk1 ({tag, ".req"},  bus.imem_req,      req);
    chk32({tag, ".addr"}, bus.imem_addr,     addr);
    chk1 ({tag, ".iv"},   bus.inst_valid,    iv);
    chk32({tag, ".inst"}, bus.inst,          ins);
    chk32({tag, ".ipc"},  bus.inst_pc,       ipc);
    chk1 ({tag, ".pnr"},  bus.pc_next_ready, pnr);
  endtask

  // ---------------- random transaction driver ----------------
  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = {8'h80, 22'($urandom_range(0, 32'h3FFFFF)), 2'($urandom_range(0, 3))};
`ifdef IFU_MISALIGN_EN
    p[1:0] = 2'b00;
`endif
    return p;
  endfunction

  // Entered at a negedge with the DUT expected to be requesting pc. Leaves
  // at a negedge: either in the next-PC phase (last) or after offering nxt.
  task automatic fetch_txn(input logic [31:0] pc, input logic [31:0] nxt, input bit last);
    int          stall, lat, bp, dly, guard;
    logic [31:0] ga, w;
    exp_q.push_back(mem_word({pc[31:2], 2'b00}));
    guard = 0;
    while (bus.imem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk1 ("rnd.req",  bus.imem_req,  1'b1);
    chk32("rnd.addr", bus.imem_addr, {pc[31:2], 2'b00});
    stall = $urandom_range(0, 3);
    for (int k = 0; k < stall; k++) begin
      bus.imem_gnt      = 1'b0;
      bus.inst_ready    = 1'($urandom_range(0, 1));
      bus.pc_next_valid = 1'($urandom_range(0, 1));
      bus.pc_next       = $urandom;
      @(negedge clk);
      chk1 ("rnd.stall_req",  bus.imem_req,  1'b1);
      chk32("rnd.stall_addr", bus.imem_addr, {pc[31:2], 2'b00});
    end
    lat = $urandom_range(0, 2);
    ga  = bus.imem_addr;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = (lat == 0);
    bus.imem_rdata  = (lat == 0) ? mem_word(ga) : $urandom;
    @(negedge clk);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      chk1("rnd.wait_req", bus.imem_req,   1'b0);
      chk1("rnd.wait_iv",  bus.inst_valid, 1'b0);
      bus.inst_ready    = 1'($urandom_range(0, 1));
      bus.pc_next_valid = 1'($urandom_range(0, 1));
      if (k == lat) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(ga);
      end
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
    end
    w  = exp_q.pop_front();
    bp = $urandom_range(0, 3);
    for (int k = 0; k <= bp; k++) begin
      chk1 ("rnd.iv",   bus.inst_valid,    1'b1);
      chk32("rnd.inst", bus.inst,          w);
      chk32("rnd.ipc",  bus.inst_pc,       pc);
      chk1 ("rnd.pnr0", bus.pc_next_ready, 1'b0);
`ifdef IFU_MISALIGN_EN
      chk1 ("rnd.mis0", bus.inst_misalign, 1'b0);
`endif
      bus.inst_ready    = (k == bp);
      bus.pc_next_valid = 1'($urandom_range(0, 1));
      bus.pc_next       = $urandom;
      @(negedge clk);
    end
    bus.inst_ready    = 1'b0;
    bus.pc_next_valid = 1'b0;
    if (last) begin
      chk1("rnd.pnr", bus.pc_next_ready, 1'b1);
      chk1("rnd.iv0", bus.inst_valid,    1'b0);
    end else begin
      dly = $urandom_range(0, 2);
      for (int k = 0; k <= dly; k++) begin
        chk1("rnd.pnr", bus.pc_next_ready, 1'b1);
        chk1("rnd.iv0", bus.inst_valid,    1'b0);
        bus.inst_ready    = 1'($urandom_range(0, 1));
        bus.pc_next_valid = (k == dly);
        bus.pc_next       = (k == dly) ? nxt : $urandom;
        @(negedge clk);
      end
      bus.pc_next_valid = 1'b0;
      bus.inst_ready    = 1'b0;
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [31:0] cur_pc, nxt_pc;
    clear_inputs();
    rst = 1'b0;

    vecs.push_back(mk(0,0,0,0,0,0,                     0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,                     1,RESET_PC,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,                     1,RESET_PC,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,                     1,RESET_PC,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,                     1,RESET_PC,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,                     0,0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h00100073,0,0,0,          0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,0,1,32'hDEADBEEF,        0,0,1,32'h00100073,RESET_PC,0));
    vecs.push_back(mk(0,0,0,1,0,0,                     0,0,1,32'h00100073,RESET_PC,0));
    vecs.push_back(mk(0,0,0,0,1,32'h80000010,          0,0,0,32'h00100073,RESET_PC,1));
    vecs.push_back(mk(1,1,32'h00000013,0,0,0,          1,32'h80000010,0,32'h00100073,RESET_PC,0));
    vecs.push_back(mk(0,0,0,1,0,0,                     0,0,1,32'h00000013,32'h80000010,0));
    vecs.push_back(mk(0,0,0,0,0,0,                     0,0,0,32'h00000013,32'h80000010,1));
    vecs.push_back(mk(0,0,0,0,1,32'h80000104,          0,0,0,32'h00000013,32'h80000010,1));
    vecs.push_back(mk(1,0,0,0,0,0,                     1,32'h80000104,0,32'h00000013,32'h80000010,0));
    vecs.push_back(mk(0,1,32'h12345678,0,0,0,          0,0,0,32'h00000013,32'h80000010,0));
    vecs.push_back(mk(0,1,32'hCAFEF00D,1,0,0,          0,0,1,32'h12345678,32'h80000104,0));
    vecs.push_back(mk(0,0,0,0,1,32'h80000200,          0,0,0,32'h12345678,32'h80000104,1));
    vecs.push_back(mk(1,0,0,0,0,0,                     1,32'h80000200,0,32'h12345678,32'h80000104,0));
    vecs.push_back(mk(0,0,0,0,0,0,                     0,0,0,32'h12345678,32'h80000104,0));

    // reset held, then released on a negedge
    repeat (3) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      bus.imem_gnt      = vecs[i].gnt;
      bus.imem_rvalid   = vecs[i].rvalid;
      bus.imem_rdata    = vecs[i].rdata;
      bus.inst_ready    = vecs[i].rdy;
      bus.pc_next_valid = vecs[i].pnv;
      bus.pc_next       = vecs[i].pnext;
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_pnr);
    end

    // reset pulse while waiting on memory; late response must be dropped
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    check_all("rst_mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBADBAD00;
    @(negedge clk);
    rst = 1'b1;
    check_all("rst_idle", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    check_all("rst_refetch", 1, RESET_PC, 0, 0, 0, 0);

    // randomized transactions, continuing from the fetch at RESET_PC
    cur_pc = RESET_PC;
    for (int t = 0; t < 30; t++) begin
      nxt_pc = rand_pc();
      fetch_txn(cur_pc, nxt_pc, t == 29);
      cur_pc = nxt_pc;
    end
    chk32("rnd.queue_empty", 32'(exp_q.size()), 32'd0);

    // misaligned next PC (DUT waiting for a next PC here)
    bus.pc_next_valid = 1'b1;
    bus.pc_next       = 32'h80000002;
    @(negedge clk);
    bus.pc_next_valid = 1'b0;
`ifdef IFU_MISALIGN_EN
    chk1 ("mis.req", bus.imem_req,      1'b0);
    chk1 ("mis.iv",  bus.inst_valid,    1'b1);
    chk1 ("mis.flag", bus.inst_misalign, 1'b1);
    chk32("mis.ipc", bus.inst_pc,       32'h80000002);
    chk32("mis.inst", bus.inst,         32'h0);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    chk1 ("mis.pnr",   bus.pc_next_ready, 1'b1);
    chk1 ("mis.clear", bus.inst_misalign, 1'b0);
`else
    chk1 ("mis.req",  bus.imem_req,  1'b1);
    chk32("mis.addr", bus.imem_addr, 32'h80000000);
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = mem_word(32'h80000000);
    @(negedge clk);
    clear_inputs();
    chk1 ("mis.iv",   bus.inst_valid, 1'b1);
    chk32("mis.inst", bus.inst,       mem_word(32'h80000000));
    chk32("mis.ipc",  bus.inst_pc,    32'h80000002);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- global time bound ----------------
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
